sdram_cmd_checker: RTL and testbench
====================================

# sdram_cmd_checker

Synthesizable SDRAM command-bus protocol checker that snoops the controller's SDRAM pins and flags protocol violations. It checks the power-up initialisation sequence (NOP window, precharge-all, auto-refreshes, mode-register load, `sdr_init_done`), then tracks per-bank open/idle state and tRCD/tRP/tRFC/tMRD spacing. Violations are reported as a one-cycle error pulse with code and bank, plus a saturating error count. It sits beside the SDRAM controller on the `sdram_clk` domain, in both simulation benches and FPGA debug builds.

## Interface
- `NUM_BANKS`, 4: number of banks tracked (power of 2, 2..8)
- `BA_W`, 2: bank address width, equal to $clog2(NUM_BANKS)
- `ADDR_W`, 13: SDRAM address width; bit 10 is the precharge-all flag
- `T_RCD`, 3: minimum cycles from ACT to RD/WR on the same bank
- `T_RP`, 3: minimum cycles from PRE to ACT on the same bank
- `T_RFC`, 7: minimum cycles from REF to any non-NOP command
- `T_MRD`, 2: minimum cycles from MRS to any non-NOP command
- `INIT_NOP`, 505: consecutive NOP cycles required before the init precharge
- `INIT_REF`, 2: auto-refreshes required during init
- `sdram_clk` in 1: clock
- `sdram_rst` in 1: asynchronous, active-high reset
- `sdr_cke` in 1: clock enable; commands are sampled only when high
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n` in 1 each: command pins
- `sdr_ba` in BA_W: bank address
- `sdr_addr` in ADDR_W: address bus
- `sdr_init_done` in 1: controller's init-complete flag
- `init_ok` out 1: init sequence completed legally
- `init_fail` out 1: init sequence violated; sticky until reset
- `err_valid` out 1: one-cycle violation pulse
- `err_code` out 4: violation code, valid with `err_valid`
- `err_bank` out BA_W: offending bank (0 for non-bank errors)
- `err_count` out 16: saturating violation count

## Operation
- Command decode, using `{cs_n,ras_n,cas_n,we_n}`: 1xxx or 0111 = NOP; 0011 = ACT; 0101 = RD; 0100 = WR; 0010 = PRE; 0001 = REF; 0000 = MRS. When `sdr_cke` is low, the cycle is treated as NOP.
- Init FSM states:
  - S_NOP counts consecutive NOPs.
  - S_NOP goes to S_PRE when the count reaches INIT_NOP.
  - S_PRE requires PRE with addr[10]=1, then goes to S_REF.
  - S_REF counts REFs (NOPs allowed) and goes to S_MRS after INIT_REF.
  - S_MRS requires MRS, then goes to S_DONE.
  - Any out-of-order non-NOP command goes to S_FAIL with code 1.
- tRFC/tMRD checks also apply during init.
- `sdr_init_done` high before the MRS has been accepted: code 9, go to S_FAIL.
- Per-bank checks are active only in S_DONE. In S_FAIL only tRFC/tMRD are checked.
- Per-bank state (IDLE/OPEN) and timers:
  - ACT loads the tRCD timer with T_RCD-1.
  - PRE loads the tRP timer with T_RP-1.
  - PRE-all loads the tRP timer of every bank and closes every bank.
- Error codes:
  - 2: ACT to an OPEN bank
  - 3: RD/WR to an IDLE bank
  - 4: tRCD violation
  - 5: tRP violation
  - 6: tRFC violation
  - 7: REF with any bank OPEN
  - 8: tMRD violation
- If several errors occur in one cycle, the lowest code is reported and `err_count` increments by 1.
- The offending command still updates state: ACT opens the bank, PRE closes it.

## Timing
- Reset values: all outputs 0; FSM in S_NOP; all banks IDLE; all timers 0.
- Error latency: `err_valid`/`err_code`/`err_bank` are registered and assert on the cycle after the offending command edge.
- Timer rule: a command at cycle n loads T-1. A dependent command at cycle n+T is legal; at n+T-1 it is flagged.
- Timers decrement every cycle, including when `sdr_cke` is low, and saturate at 0.
- `init_ok` rises on the cycle after the MRS edge, provided `sdr_init_done` was low up to that edge.
- `err_count` holds at 0xFFFF once saturated.
- Reset asserted mid-operation clears everything asynchronously. Checking restarts from S_NOP.

## Configuration
- `SDRAM_CHK_CMD_CNT_EN`:
  - Defined: adds outputs `cnt_act`, `cnt_rd`, `cnt_wr`, `cnt_pre`, `cnt_ref`, 16-bit each. They count accepted commands from S_DONE onward, saturate at 0xFFFF, and reset to 0.
  - Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- `sdram_chk_pkg`: `cmd_e` enum, `err_e` enum (codes 0–9), and `decode_cmd()` function.
- Sub-module `sdram_chk_bank`:
  - Per-bank state bit plus tRCD and tRP timers.
  - Inputs: decoded command, bank-hit, precharge-all.
  - Outputs: violation flags for codes 2–5.
  - Instantiated NUM_BANKS times in a generate loop.
- Top level holds the init FSM, the REF/MRS timers, priority encoding, and `err_count`.

## Test plan
- Legal init (505 NOP, PRE-all, 2×REF spaced 8, MRS, then `sdr_init_done`) → `init_ok`=1, `err_count`=0.
- ACT at NOP count 300 → `init_fail`=1, `err_code`=1 on the next cycle.
- In S_DONE, ACT bank 2 then RD bank 2 two cycles later → `err_code`=4, `err_bank`=2. A RD three cycles after ACT → no error.
- ACT bank 1, then ACT bank 1 again → code 2. REF with bank 1 still OPEN → code 7.
- REF followed by ACT 5 cycles later → code 6. 70000 such violations → `err_count`=0xFFFF.
- Reset pulse mid-sequence after 2 errors → all outputs 0. The legal init is then re-run and passes.

Source files
------------

// File: rtl/sdram_chk_pkg.sv
// Shared types for the SDRAM command-bus checker: command and violation codes,
// init-sequence states, and the pin-level command decoder.
package sdram_chk_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS
    } cmd_e;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_ORDER      = 4'd1,
        ERR_ACT_OPEN   = 4'd2,
        ERR_RW_IDLE    = 4'd3,
        ERR_TRCD       = 4'd4,
        ERR_TRP        = 4'd5,
        ERR_TRFC       = 4'd6,
        ERR_REF_OPEN   = 4'd7,
        ERR_TMRD       = 4'd8,
        ERR_EARLY_DONE = 4'd9
    } err_e;

    typedef enum logic [2:0] {
        S_NOP,
        S_PRE,
        S_REF,
        S_MRS,
        S_DONE,
        S_FAIL
    } init_e;

    localparam int TIMER_W = 8;

    // Unlisted encodings (e.g. burst terminate, 0110) are ignored like a NOP.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        cmd_e c;
        c = CMD_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  c = CMD_ACT;
                3'b101:  c = CMD_RD;
                3'b100:  c = CMD_WR;
                3'b010:  c = CMD_PRE;
                3'b001:  c = CMD_REF;
                3'b000:  c = CMD_MRS;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sdram_cmd_checker_bank.sv
// One bank's open/idle bit with its tRCD and tRP down-counters and violation flags.
module sdram_chk_bank
    import sdram_chk_pkg::*;
#(
    parameter int T_RCD = 3,
    parameter int T_RP  = 3
) (
    input  logic clk,
    input  logic rst,
    input  cmd_e cmd,
    input  logic hit,
    input  logic pre_all,
    output logic is_open,
    output logic err_act_open,
    output logic err_rw_idle,
    output logic err_trcd,
    output logic err_trp
);
    localparam logic [TIMER_W-1:0] RCD_LOAD = TIMER_W'(T_RCD - 1);
    localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 1);

    logic [TIMER_W-1:0] trcd_q;
    logic [TIMER_W-1:0] trp_q;
    logic               rw;

    assign rw           = (cmd == CMD_RD) || (cmd == CMD_WR);
    assign err_act_open = hit && (cmd == CMD_ACT) && is_open;
    assign err_rw_idle  = hit && rw && !is_open;
    assign err_trcd     = hit && rw && (trcd_q != '0);
    assign err_trp      = hit && (cmd == CMD_ACT) && (trp_q != '0);

    // Offending commands still update state, so later checks follow the real bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_open <= 1'b0;
            trcd_q  <= '0;
            trp_q   <= '0;
        end else begin
            if (hit && cmd == CMD_ACT) begin
                is_open <= 1'b1;
                trcd_q  <= RCD_LOAD;
            end else if (trcd_q != '0) begin
                trcd_q <= trcd_q - TIMER_W'(1);
            end
            if (cmd == CMD_PRE && (hit || pre_all)) begin
                is_open <= 1'b0;
                trp_q   <= RP_LOAD;
            end else if (trp_q != '0) begin
                trp_q <= trp_q - TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_checker.sv
// SDRAM command-bus protocol checker: init sequence FSM, tRFC/tMRD timers, per-bank
// trackers and error reporting. Optional SDRAM_CHK_CMD_CNT_EN adds command counters.
//
//   state  | meaning
//   S_NOP  | counting the power-up NOP window
//   S_PRE  | waiting for precharge-all
//   S_REF  | counting init auto-refreshes
//   S_MRS  | waiting for mode-register load
//   S_DONE | init complete, full bank checking
//   S_FAIL | init violated (sticky), only tRFC/tMRD checked
module sdram_cmd_checker
    import sdram_chk_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int ADDR_W    = 13,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int INIT_NOP  = 505,
    parameter int INIT_REF  = 2
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [BA_W-1:0]   sdr_ba,
    input  logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_init_done,
    output logic              init_ok,
    output logic              init_fail,
    output logic              err_valid,
    output logic [3:0]        err_code,
    output logic [BA_W-1:0]   err_bank,
    output logic [15:0]       err_count
`ifdef SDRAM_CHK_CMD_CNT_EN
   ,output logic [15:0]       cnt_act,
    output logic [15:0]       cnt_rd,
    output logic [15:0]       cnt_wr,
    output logic [15:0]       cnt_pre,
    output logic [15:0]       cnt_ref
`endif
);
    localparam int NOP_W = $clog2(INIT_NOP + 1);
    localparam int REF_W = $clog2(INIT_REF + 1);
    localparam logic [NOP_W-1:0]   NOP_LAST = NOP_W'(INIT_NOP - 1);
    localparam logic [REF_W-1:0]   REF_LAST = REF_W'(INIT_REF - 1);
    localparam logic [TIMER_W-1:0] RFC_LOAD = TIMER_W'(T_RFC - 1);
    localparam logic [TIMER_W-1:0] MRD_LOAD = TIMER_W'(T_MRD - 1);

    cmd_e               cmd;
    logic               non_nop;
    logic               pre_all;
    logic               bank_chk;
    init_e              state_q, state_d;
    logic [NOP_W-1:0]   nop_cnt_q, nop_cnt_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [TIMER_W-1:0] trfc_q, tmrd_q;
    logic               order_err, early_done;
    logic [NUM_BANKS-1:0] open_v, act_open_v, rw_idle_v, trcd_v, trp_v;
    err_e               code_d;
    logic [BA_W-1:0]    bank_d;
    logic               unused_addr;

    assign cmd         = decode_cmd(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
    assign non_nop     = (cmd != CMD_NOP);
    assign pre_all     = (cmd == CMD_PRE) && sdr_addr[10];
    assign bank_chk    = (state_q == S_DONE);
    assign init_ok     = (state_q == S_DONE);
    assign init_fail   = (state_q == S_FAIL);
    assign unused_addr = ^{sdr_addr[ADDR_W-1:11], sdr_addr[9:0]};

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        sdram_chk_bank #(
            .T_RCD(T_RCD),
            .T_RP (T_RP)
        ) u_bank (
            .clk         (sdram_clk),
            .rst         (sdram_rst),
            .cmd         (cmd),
            .hit         (sdr_ba == BA_W'(i)),
            .pre_all     (pre_all),
            .is_open     (open_v[i]),
            .err_act_open(act_open_v[i]),
            .err_rw_idle (rw_idle_v[i]),
            .err_trcd    (trcd_v[i]),
            .err_trp     (trp_v[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        nop_cnt_d  = nop_cnt_q;
        ref_cnt_d  = ref_cnt_q;
        order_err  = 1'b0;
        early_done = 1'b0;
        case (state_q)
            S_NOP: begin
                if (non_nop)                  order_err = 1'b1;
                else if (nop_cnt_q == NOP_LAST) state_d = S_PRE;
                else                          nop_cnt_d = nop_cnt_q + NOP_W'(1);
            end
            S_PRE: begin
                if (pre_all)      state_d   = S_REF;
                else if (non_nop) order_err = 1'b1;
            end
            S_REF: begin
                if (cmd == CMD_REF) begin
                    if (ref_cnt_q == REF_LAST) state_d   = S_MRS;
                    else                       ref_cnt_d = ref_cnt_q + REF_W'(1);
                end else if (non_nop) begin
                    order_err = 1'b1;
                end
            end
            S_MRS: begin
                if (cmd == CMD_MRS) state_d   = S_DONE;
                else if (non_nop)   order_err = 1'b1;
            end
            default: ;
        endcase
        // The controller must not claim init-complete until the MRS edge has passed.
        if (state_q inside {S_NOP, S_PRE, S_REF, S_MRS} && sdr_init_done) early_done = 1'b1;
        if (order_err || early_done) state_d = S_FAIL;
    end

    always_comb begin
        code_d = ERR_NONE;
        bank_d = '0;
        if (order_err) begin
            code_d = ERR_ORDER;
        end else if (bank_chk && |act_open_v) begin
            code_d = ERR_ACT_OPEN;
            bank_d = sdr_ba;
        end else if (bank_chk && |rw_idle_v) begin
            code_d = ERR_RW_IDLE;
            bank_d = sdr_ba;
        end else if (bank_chk && |trcd_v) begin
            code_d = ERR_TRCD;
            bank_d = sdr_ba;
        end else if (bank_chk && |trp_v) begin
            code_d = ERR_TRP;
            bank_d = sdr_ba;
        end else if (non_nop && trfc_q != '0) begin
            code_d = ERR_TRFC;
        end else if (bank_chk && cmd == CMD_REF && |open_v) begin
            code_d = ERR_REF_OPEN;
        end else if (non_nop && tmrd_q != '0) begin
            code_d = ERR_TMRD;
        end else if (early_done) begin
            code_d = ERR_EARLY_DONE;
        end
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q   <= S_NOP;
            nop_cnt_q <= '0;
            ref_cnt_q <= '0;
            trfc_q    <= '0;
            tmrd_q    <= '0;
            err_valid <= 1'b0;
            err_code  <= 4'd0;
            err_bank  <= '0;
            err_count <= 16'd0;
        end else begin
            state_q   <= state_d;
            nop_cnt_q <= nop_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            if (cmd == CMD_REF)    trfc_q <= RFC_LOAD;
            else if (trfc_q != '0) trfc_q <= trfc_q - TIMER_W'(1);
            if (cmd == CMD_MRS)    tmrd_q <= MRD_LOAD;
            else if (tmrd_q != '0) tmrd_q <= tmrd_q - TIMER_W'(1);
            err_valid <= (code_d != ERR_NONE);
            err_code  <= code_d;
            err_bank  <= bank_d;
            if (code_d != ERR_NONE) err_count <= sat_inc16(err_count);
        end
    end

`ifdef SDRAM_CHK_CMD_CNT_EN
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            cnt_act <= 16'd0;
            cnt_rd  <= 16'd0;
            cnt_wr  <= 16'd0;
            cnt_pre <= 16'd0;
            cnt_ref <= 16'd0;
        end else if (state_q == S_DONE) begin
            case (cmd)
                CMD_ACT: cnt_act <= sat_inc16(cnt_act);
                CMD_RD:  cnt_rd  <= sat_inc16(cnt_rd);
                CMD_WR:  cnt_wr  <= sat_inc16(cnt_wr);
                CMD_PRE: cnt_pre <= sat_inc16(cnt_pre);
                CMD_REF: cnt_ref <= sat_inc16(cnt_ref);
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_checker.sv
// Randomized bench for sdram_cmd_checker against a timestamp-based protocol model.
module tb_sdram_cmd_checker;
    localparam int NB = 4, BA_W = 2, ADDR_W = 13;
    localparam int T_RCD = 3, T_RP = 3, T_RFC = 7, T_MRD = 2, INIT_NOP = 505, INIT_REF = 2;
    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5, C_MRS = 6;

    logic clk = 1'b0, rst = 1'b1, cke = 1'b0, init_done = 1'b0;
    logic cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [BA_W-1:0]   ba = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic init_ok, init_fail, err_valid;
    logic [3:0]  err_code;
    logic [BA_W-1:0] err_bank;
    logic [15:0] err_count;
`ifdef SDRAM_CHK_CMD_CNT_EN
    logic [15:0] cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;
`endif

    always #5 clk = ~clk;

    sdram_cmd_checker dut (
        .sdram_clk(clk), .sdram_rst(rst), .sdr_cke(cke), .sdr_cs_n(cs_n), .sdr_ras_n(ras_n),
        .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba), .sdr_addr(addr), .sdr_init_done(init_done),
        .init_ok(init_ok), .init_fail(init_fail), .err_valid(err_valid), .err_code(err_code),
        .err_bank(err_bank), .err_count(err_count)
`ifdef SDRAM_CHK_CMD_CNT_EN
       ,.cnt_act(cnt_act), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_pre(cnt_pre), .cnt_ref(cnt_ref)
`endif
    );

    int n_cmp = 0, n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Model: protocol rules expressed as cycle timestamps and init progress counts.
    longint cyc, t_ref, t_mrs;
    longint t_act[NB], t_pre[NB];
    bit     open_b[NB];
    int     nops, refs, m_cnt, m_code, m_bank;
    bit     pre_ok, done, failed;

    task automatic model_reset();
        cyc = 0; t_ref = -1000; t_mrs = -1000;
        for (int i = 0; i < NB; i++) begin
            t_act[i] = -1000; t_pre[i] = -1000; open_b[i] = 0;
        end
        nops = 0; refs = 0; m_cnt = 0; m_code = 0; m_bank = 0;
        pre_ok = 0; done = 0; failed = 0;
    endtask

    task automatic model_cmd(input int c, input int b, input bit a10, input bit idone);
        bit e[10];
        bit nonnop, ok, any_open, rw;
        for (int k = 0; k < 10; k++) e[k] = 0;
        nonnop = (c != C_NOP);
        rw     = (c == C_RD) || (c == C_WR);
        if (!failed && !done) begin
            if (nops < INIT_NOP)      ok = !nonnop;
            else if (!pre_ok)         ok = !nonnop || (c == C_PRE && a10);
            else if (refs < INIT_REF) ok = !nonnop || (c == C_REF);
            else                      ok = !nonnop || (c == C_MRS);
            e[1] = !ok;
            e[9] = idone;
        end
        if (nonnop && cyc - t_ref < T_RFC) e[6] = 1;
        if (nonnop && cyc - t_mrs < T_MRD) e[8] = 1;
        if (done) begin
            any_open = 0;
            for (int i = 0; i < NB; i++) any_open |= open_b[i];
            e[2] = (c == C_ACT) && open_b[b];
            e[3] = rw && !open_b[b];
            e[4] = rw && (cyc - t_act[b] < T_RCD);
            e[5] = (c == C_ACT) && (cyc - t_pre[b] < T_RP);
            e[7] = (c == C_REF) && any_open;
        end
        m_code = 0;
        for (int k = 9; k >= 1; k--) if (e[k]) m_code = k;
        m_bank = (m_code >= 2 && m_code <= 5) ? b : 0;
        if (m_code != 0 && m_cnt < 65535) m_cnt++;
        if (!failed && !done) begin
            if (e[1] || e[9])          failed = 1;
            else if (nops < INIT_NOP)  nops++;
            else if (!pre_ok)          pre_ok = (c == C_PRE);
            else if (refs < INIT_REF)  refs += (c == C_REF) ? 1 : 0;
            else if (c == C_MRS)       done = 1;
        end
        if (c == C_ACT) begin open_b[b] = 1; t_act[b] = cyc; end
        if (c == C_PRE) begin
            for (int i = 0; i < NB; i++)
                if (a10 || i == b) begin open_b[i] = 0; t_pre[i] = cyc; end
        end
        if (c == C_REF) t_ref = cyc;
        if (c == C_MRS) t_mrs = cyc;
        cyc++;
    endtask

    // Called shortly after a rising edge: drive, advance model, check after the next edge.
    task automatic step(input int c, input int b, input bit a10, input bit ck, input bit idone, input bit chk);
        logic [3:0] p;
        case (c)
            C_ACT:   p = 4'b0011;
            C_RD:    p = 4'b0101;
            C_WR:    p = 4'b0100;
            C_PRE:   p = 4'b0010;
            C_REF:   p = 4'b0001;
            C_MRS:   p = 4'b0000;
            default: p = ($urandom_range(0, 1) == 1) ? 4'b0111 : {1'b1, 3'($urandom_range(0, 7))};
        endcase
        if (!ck) p = 4'($urandom_range(0, 15));
        {cs_n, ras_n, cas_n, we_n} = p;
        cke       = ck;
        ba        = BA_W'(b);
        addr      = ADDR_W'($urandom);
        addr[10]  = a10;
        init_done = idone;
        model_cmd(ck ? c : C_NOP, b, a10, idone);
        @(posedge clk);
        #1;
        if (chk) begin
            check_val("err_valid", 32'(err_valid), 32'(m_code != 0));
            check_val("err_code",  32'(err_code),  32'(m_code));
            check_val("err_bank",  32'(err_bank),  32'(m_bank));
            check_val("err_count", 32'(err_count), 32'(m_cnt));
            check_val("init_ok",   32'(init_ok),   32'(done));
            check_val("init_fail", 32'(init_fail), 32'(failed));
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_valid"}, 32'(err_valid), 32'd0);
        check_val({tag, "_code"},  32'(err_code),  32'd0);
        check_val({tag, "_bank"},  32'(err_bank),  32'd0);
        check_val({tag, "_count"}, 32'(err_count), 32'd0);
        check_val({tag, "_ok"},    32'(init_ok),   32'd0);
        check_val({tag, "_fail"},  32'(init_fail), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cke = 1'b0; cs_n = 1'b1; init_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic legal_init();
        repeat (INIT_NOP) step(C_NOP, 0, 0, 1, 0, 1);
        step(C_PRE, 0, 1, 1, 0, 1);
        repeat (INIT_REF) begin
            repeat (7) step(C_NOP, 0, 0, 1, 0, 1);
            step(C_REF, 0, 0, 1, 0, 1);
        end
        repeat (7) step(C_NOP, 0, 0, 1, 0, 1);
        step(C_MRS, 0, 0, 1, 0, 1);
        step(C_NOP, 0, 0, 1, 1, 1);
        check_val("init_ok_after_mrs", 32'(init_ok), 32'd1);
        check_val("init_clean_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        int r, c, n;
        do_reset();

        repeat (300) step(C_NOP, 0, 0, 1, 0, 1);
        step(C_ACT, 1, 0, 1, 0, 1);
        check_val("early_act_code", 32'(err_code), 32'd1);
        check_val("early_act_fail", 32'(init_fail), 32'd1);
        step(C_REF, 0, 0, 1, 0, 1);
        step(C_REF, 0, 0, 1, 0, 1);
        check_val("fail_trfc_code", 32'(err_code), 32'd6);

        do_reset();
        repeat (10) step(C_NOP, 0, 0, 1, 0, 1);
        step(C_NOP, 0, 0, 1, 1, 1);
        check_val("early_done_code", 32'(err_code), 32'd9);

        do_reset();
        legal_init();

        step(C_ACT, 2, 0, 1, 1, 1);
        step(C_NOP, 0, 0, 1, 1, 1);
        step(C_RD, 2, 0, 1, 1, 1);
        check_val("trcd_code", 32'(err_code), 32'd4);
        check_val("trcd_bank", 32'(err_bank), 32'd2);
        step(C_PRE, 2, 0, 1, 1, 1);
        repeat (2) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_ACT, 2, 0, 1, 1, 1);
        repeat (2) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_RD, 2, 0, 1, 1, 1);
        check_val("trcd_ok_valid", 32'(err_valid), 32'd0);

        step(C_ACT, 1, 0, 1, 1, 1);
        repeat (3) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_ACT, 1, 0, 1, 1, 1);
        check_val("act_open_code", 32'(err_code), 32'd2);
        check_val("act_open_bank", 32'(err_bank), 32'd1);
        step(C_NOP, 0, 0, 1, 1, 1);
        step(C_REF, 0, 0, 1, 1, 1);
        check_val("ref_open_code", 32'(err_code), 32'd7);
        repeat (8) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_PRE, 0, 1, 1, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            c = (r < 45) ? C_NOP : (r < 60) ? C_ACT : (r < 70) ? C_RD : (r < 80) ? C_WR :
                (r < 92) ? C_PRE : (r < 97) ? C_REF : C_MRS;
            step(c, $urandom_range(0, NB - 1), $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0, 1, 1);
        end

        repeat (8) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_PRE, 0, 1, 1, 1, 1);
        repeat (8) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_REF, 0, 0, 1, 1, 1);
        repeat (4) step(C_NOP, 0, 0, 1, 1, 1);
        step(C_ACT, 0, 0, 1, 1, 1);
        check_val("trfc_code", 32'(err_code), 32'd6);
        n = 65535 - m_cnt + 8;
        repeat (n) step(C_REF, 0, 0, 1, 1, 0);
        step(C_NOP, 0, 0, 1, 1, 1);
        check_val("sat_count", 32'(err_count), 32'hFFFF);
        step(C_REF, 0, 0, 1, 1, 1);
        check_val("sat_hold", 32'(err_count), 32'hFFFF);

        do_reset();
        legal_init();
        step(C_ACT, 0, 0, 1, 1, 1);
        step(C_ACT, 0, 0, 1, 1, 1);
        step(C_ACT, 0, 0, 1, 1, 1);
        check_val("pre_rst_count", 32'(err_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        legal_init();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
